// File: rtl/ball_physics.sv
// ball_physics: per-frame vertical motion generator for the ball.
// Produces a registered signed Y step (two's complement, positive = down)
// from keyboard jump requests, ground contact and ceiling contact, with a
// divided-down gravity tick and terminal fall speed.
//
// Ports:
//   frame_clk   - only clock, all state updates on its rising edge
//   Reset       - synchronous active-low reset
//   keycode     - current keyboard keycode (jump on JUMP_KEY press edge)
//   on_ground   - ball rests on floor or platform top
//   hit_ceiling - ball top touches an obstacle
//   Y_Motion    - registered signed Y step, 10-bit two's complement
//   Airborne    - 1 whenever the ball is not GROUNDED
//   Land        - one-cycle pulse on the landing edge
//   Jump_Count  - accepted jumps, wraps modulo 256
//   dbg_state   - current FSM state (GROUNDED/RISING/FALLING)
//
// Handshake: none; inputs are level signals sampled on every frame_clk
// edge and every output is a register, so any input change is visible
// on the outputs exactly one edge later.
module ball_physics #(
  parameter logic [9:0] JUMP_V   = 10'd8,
  parameter logic [9:0] GRAVITY  = 10'd1,
  parameter logic [3:0] GRAV_DIV = 4'd2,
  parameter logic [9:0] MAX_FALL = 10'd6,
  parameter logic [7:0] JUMP_KEY = 8'd26
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       on_ground,
  input  logic       hit_ceiling,
  output logic [9:0] Y_Motion,
  output logic       Airborne,
  output logic       Land,
  output logic [7:0] Jump_Count,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] GROUNDED = 2'd0;
  localparam logic [1:0] RISING   = 2'd1;
  localparam logic [1:0] FALLING  = 2'd2;

  logic [1:0]  state, state_n;
  logic [7:0]  prev_key;
  logic [3:0]  grav_cnt, cnt_n;
  logic [9:0]  y_n;
  logic        land_n;
  logic [7:0]  jc_n;
  logic        jump_edge;
  logic        tick;
  logic [9:0]  rise_sum;
  logic [10:0] fall_sum;

  assign jump_edge = (keycode == JUMP_KEY) && (prev_key != JUMP_KEY);
  assign tick      = (grav_cnt == (GRAV_DIV - 4'd1));
  assign rise_sum  = Y_Motion + GRAVITY;
  // Falling speed is never negative, so an unsigned 11-bit sum cannot wrap
  // and compares directly against the terminal speed.
  assign fall_sum  = {1'b0, Y_Motion} + {1'b0, GRAVITY};
  assign dbg_state = state;

  always_comb begin
    state_n = state;
    y_n     = Y_Motion;
    land_n  = 1'b0;
    jc_n    = Jump_Count;
    case (state)
      GROUNDED: begin
        y_n = 10'd0;
        if (jump_edge) begin
          state_n = RISING;
          y_n     = -JUMP_V;
          jc_n    = Jump_Count + 8'd1;
        end else if (!on_ground) begin
          state_n = FALLING;
        end
      end
      RISING: begin
        // Ground contact and jump presses are ignored: the ball passes up
        // through platforms from below.
        if (hit_ceiling) begin
          state_n = FALLING;
          y_n     = 10'd0;
        end else if (tick) begin
          if (!rise_sum[9]) begin
            state_n = FALLING;
            y_n     = 10'd0;
          end else begin
            y_n = rise_sum;
          end
        end
      end
      FALLING: begin
        if (on_ground) begin
          state_n = GROUNDED;
          y_n     = 10'd0;
          land_n  = 1'b1;
        end else if (tick) begin
          if (fall_sum > {1'b0, MAX_FALL}) y_n = MAX_FALL;
          else                             y_n = fall_sum[9:0];
        end
      end
      default: begin
        state_n = GROUNDED;
        y_n     = 10'd0;
      end
    endcase

    // Gravity phase restarts on every state change so each new flight
    // phase begins with a full GRAV_DIV period before its first tick.
    if (state_n != state) cnt_n = 4'd0;
    else if (tick)        cnt_n = 4'd0;
    else                  cnt_n = grav_cnt + 4'd1;
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      state      <= GROUNDED;
      prev_key   <= 8'd0;
      grav_cnt   <= 4'd0;
      Y_Motion   <= 10'd0;
      Airborne   <= 1'b0;
      Land       <= 1'b0;
      Jump_Count <= 8'd0;
    end else begin
      state      <= state_n;
      prev_key   <= keycode;
      grav_cnt   <= cnt_n;
      Y_Motion   <= y_n;
      Airborne   <= (state_n != GROUNDED);
      Land       <= land_n;
      Jump_Count <= jc_n;
    end
  end

endmodule
